// File: rtl/sub_result_buffer_pkg.sv
// Shared ALU types: subtractor flag bundle and result-buffer occupancy states.
// Imported by the result buffer, its interface and benches.
package alu_pkg;

    localparam int FLAGS_W = 4;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    function automatic flags_t pack_flags(
        input logic n,
        input logic z,
        input logic c,
        input logic v
    );
        flags_t f;
        f.n = n;
        f.z = z;
        f.c = c;
        f.v = v;
        return f;
    endfunction

endpackage

// File: rtl/sub_result_buffer_if.sv
// Handshake bundle between the subtractor, the result buffer and its consumer.
// slave = buffer side, master = producer/consumer side.
interface sub_result_buffer_if #(
    parameter int WIDTH = 32
) ();
    import alu_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       Sub;
    logic                   N;
    logic                   Z;
    logic                   C;
    logic                   V;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       Result;
    logic [FLAGS_W-1:0]     Flags;

    modport slave (
        input  in_valid,
        input  Sub,
        input  N,
        input  Z,
        input  C,
        input  V,
        input  out_ready,
        output in_ready,
        output out_valid,
        output Result,
        output Flags
    );

    modport master (
        output in_valid,
        output Sub,
        output N,
        output Z,
        output C,
        output V,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Result,
        input  Flags
    );

endinterface

// File: rtl/sub_result_buffer.sv
// Two-entry skid buffer for subtractor results and flags, with op counter.
// Optional STICKY_FLAGS_EN adds sticky {C,V} with a clear input.
module sub_result_buffer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sub_result_buffer_if.slave   bus,
    output logic [CNT_W-1:0]     Op_count
`ifdef STICKY_FLAGS_EN
    ,
    output logic [1:0]           Sticky_CV,
    input  logic                 clr_sticky
`endif
);

    buf_state_t         state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [WIDTH-1:0]   head_data_q, head_data_d;
    flags_t             head_flags_q, head_flags_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    flags_t             skid_flags_q, skid_flags_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               out_valid;
    logic               push;
    logic               pop;
    flags_t             in_flags;

    assign out_valid = (state_q != EMPTY);
    assign push      = bus.in_valid & in_ready_q;
    assign pop       = out_valid & bus.out_ready;
    assign in_flags  = pack_flags(bus.N, bus.Z, bus.C, bus.V);

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.Result    = head_data_q;
    assign bus.Flags     = head_flags_q;
    assign Op_count      = cnt_q;

    always_comb begin
        state_d      = state_q;
        head_data_d  = head_data_q;
        head_flags_d = head_flags_q;
        skid_data_d  = skid_data_q;
        skid_flags_d = skid_flags_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_data_d  = bus.Sub;
                    head_flags_d = in_flags;
                    state_d      = ONE;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    skid_data_d  = bus.Sub;
                    skid_flags_d = in_flags;
                    state_d      = TWO;
                end else if (pop && !push) begin
                    state_d      = EMPTY;
                end else if (push && pop) begin
                    head_data_d  = bus.Sub;
                    head_flags_d = in_flags;
                end
            end
            TWO: begin
                if (pop) begin
                    head_data_d  = skid_data_q;
                    head_flags_d = skid_flags_q;
                    state_d      = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Registered ready: next-cycle occupancy decides, never out_ready directly
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            head_data_q  <= '0;
            head_flags_q <= '0;
            skid_data_q  <= '0;
            skid_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            head_data_q  <= head_data_d;
            head_flags_q <= head_flags_d;
            skid_data_q  <= skid_data_d;
            skid_flags_q <= skid_flags_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef STICKY_FLAGS_EN
    logic [1:0] sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        // Clear wins over a same-cycle merge
        if (clr_sticky) begin
            sticky_d = 2'b00;
        end else if (push) begin
            sticky_d = sticky_q | {in_flags.c, in_flags.v};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 2'b00;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign Sticky_CV = sticky_q;
`endif

endmodule

// File: tb/tb_sub_result_buffer.sv
// Self-checking bench for sub_result_buffer: vector table, corner sequences,
// and randomized traffic against a queue-based FIFO model.
module tb_sub_result_buffer;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] op_count;
`ifdef STICKY_FLAGS_EN
    logic [1:0]       sticky_cv;
    logic             clr_sticky;
`endif

    int errors = 0;
    int checks = 0;

    logic [35:0] mq[$];
    int          m_cnt;
    logic [1:0]  m_sticky;

    always #5 clk = ~clk;

    sub_result_buffer_if #(.WIDTH(WIDTH)) bus ();

    sub_result_buffer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .Op_count (op_count)
`ifdef STICKY_FLAGS_EN
        ,
        .Sticky_CV  (sticky_cv),
        .clr_sticky (clr_sticky)
`endif
    );

    typedef struct {
        logic [31:0] sub;
        logic [3:0]  f;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;
        int          exp_cnt;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] d,
                         input logic [3:0] f, input logic ordy,
                         input logic clr);
        bus.in_valid  = iv;
        bus.Sub       = d;
        bus.N         = f[3];
        bus.Z         = f[2];
        bus.C         = f[1];
        bus.V         = f[0];
        bus.out_ready = ordy;
`ifdef STICKY_FLAGS_EN
        clr_sticky    = clr;
`else
        if (clr) begin end
`endif
    endtask

    // One clock: model follows FIFO rules, then all outputs compared
    task automatic cycle(input logic iv, input logic [31:0] d,
                         input logic [3:0] f, input logic ordy,
                         input logic clr);
        bit push, pop;
        push = iv && (mq.size() < 2);
        pop  = ordy && (mq.size() > 0);
        drive(iv, d, f, ordy, clr);
        @(posedge clk);
        #1;
        if (pop) mq.delete(0);
        if (push) begin
            mq.push_back({d, f});
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
        if (clr) m_sticky = 2'b00;
        else if (push) m_sticky = m_sticky | f[1:0];
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
        chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < 2));
        if (mq.size() > 0) begin
            chk("Result", 64'(bus.Result), 64'(mq[0][35:4]));
            chk("Flags", 64'(bus.Flags), 64'(mq[0][3:0]));
        end
        chk("Op_count", 64'(op_count), 64'(m_cnt));
`ifdef STICKY_FLAGS_EN
        chk("Sticky_CV", 64'(sticky_cv), 64'(m_sticky));
`endif
    endtask

    task automatic do_reset(input logic iv);
        rst = 1'b1;
        drive(iv, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        m_cnt    = 0;
        m_sticky = 2'b00;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_Result", 64'(bus.Result), 64'd0);
        chk("rst_Flags", 64'(bus.Flags), 64'd0);
        chk("rst_Op_count", 64'(op_count), 64'd0);
`ifdef STICKY_FLAGS_EN
        chk("rst_Sticky", 64'(sticky_cv), 64'd0);
`endif
        rst = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{32'hFFFF_FFFE, 4'b1010, 32'hFFFF_FFFE, 4'b1010, 1};
        tbl[1] = '{32'h0000_0000, 4'b0100, 32'h0000_0000, 4'b0100, 2};
        tbl[2] = '{32'h7FFF_FFFF, 4'b0001, 32'h7FFF_FFFF, 4'b0001, 3};
        tbl[3] = '{32'h8000_0000, 4'b1011, 32'h8000_0000, 4'b1011, 4};
        tbl[4] = '{32'h1234_5678, 4'b0000, 32'h1234_5678, 4'b0000, 5};

        do_reset(1'b0);

        // Table: one op per cycle, visible the next cycle
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, tbl[i].sub, tbl[i].f, 1'b1, 1'b0);
            chk("tbl_valid", 64'(bus.out_valid), 64'd1);
            chk("tbl_Result", 64'(bus.Result), 64'(tbl[i].exp_res));
            chk("tbl_Flags", 64'(bus.Flags), 64'(tbl[i].exp_flags));
            chk("tbl_count", 64'(op_count), 64'(tbl[i].exp_cnt));
        end
        cycle(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("drain_empty", 64'(bus.out_valid), 64'd0);

        // Stall: fill both entries, hold a third, then drain in order
        do_reset(1'b0);
        cycle(1'b1, 32'h1, 4'h0, 1'b0, 1'b0);
        chk("stall_rdy1", 64'(bus.in_ready), 64'd1);
        cycle(1'b1, 32'h2, 4'h0, 1'b0, 1'b0);
        chk("stall_rdy0", 64'(bus.in_ready), 64'd0);
        cycle(1'b1, 32'h3, 4'h0, 1'b0, 1'b0);
        chk("stall_hold", 64'(bus.Result), 64'h1);
        chk("stall_cnt", 64'(op_count), 64'd2);
        cycle(1'b1, 32'h3, 4'h0, 1'b1, 1'b0);
        chk("stall_out2", 64'(bus.Result), 64'h2);
        chk("stall_rdy_back", 64'(bus.in_ready), 64'd1);
        cycle(1'b1, 32'h3, 4'h0, 1'b1, 1'b0);
        chk("stall_out3", 64'(bus.Result), 64'h3);
        chk("stall_cnt3", 64'(op_count), 64'd3);
        cycle(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("stall_empty", 64'(bus.out_valid), 64'd0);
        cycle(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

        // Back-to-back at full rate
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'hA000_0000 + 32'(i), 4'(i), 1'b1, 1'b0);
            chk("b2b_Result", 64'(bus.Result), 64'(32'hA000_0000 + 32'(i)));
            chk("b2b_ready", 64'(bus.in_ready), 64'd1);
        end
        chk("b2b_count", 64'(op_count), 64'd8);

        // Counter wrap at 2^CNT_W
        do_reset(1'b0);
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 32'(i), 4'h0, 1'b1, 1'b0);
        end
        chk("wrap_count", 64'(op_count), 64'd1);

`ifdef STICKY_FLAGS_EN
        do_reset(1'b0);
        cycle(1'b1, 32'h10, 4'b0001, 1'b1, 1'b0);
        chk("sticky_v", 64'(sticky_cv), 64'b01);
        cycle(1'b1, 32'h11, 4'b0000, 1'b1, 1'b0);
        chk("sticky_keep", 64'(sticky_cv), 64'b01);
        cycle(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
        chk("sticky_idle", 64'(sticky_cv), 64'b01);
        cycle(1'b1, 32'h12, 4'b0010, 1'b1, 1'b1);
        chk("sticky_clr", 64'(sticky_cv), 64'b00);
`endif

        // Random traffic against the FIFO model
        do_reset(1'b0);
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0));
        end

        // Reset mid-operation with concurrent traffic
        cycle(1'b1, 32'h55, 4'h5, 1'b0, 1'b0);
        do_reset(1'b1);
        cycle(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("post_rst_empty", 64'(bus.out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
